alu_result_buffer: RTL
======================

# alu_result_buffer

Registered output stage directly downstream of the 8-bit signed arithmetic unit. It captures each result, its Op code and its Overflow/Zero/Negative flags through a valid/ready handshake. Entries are held in a small first-word-fall-through FIFO so the consumer can stall without stalling the ALU. It also keeps sticky overflow status for software.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- WIDTH, 8, result width; matches the arithmetic unit
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- InValid  in  1  producer has a result this cycle
- InReady  out  1  buffer can accept; equals Count < DEPTH
- InOp  in  2  Op that produced the result: 00 add, 01 sub, 10 compare, 11 absdiff
- InResult  in  WIDTH  signed result
- InOverflow / InZero / InNegative  in  1 each  ALU flags
- OutValid  out  1  head entry valid; equals Count != 0
- OutReady  in  1  consumer takes the head entry
- OutOp  out  2  head Op
- OutResult  out  WIDTH  head result
- OutFlags  out  3  head flags as {Overflow, Zero, Negative}
- Count  out  $clog2(DEPTH)+1  occupancy
- ClearSticky  in  1  clears the sticky status
- StickyOverflow  out  1  set when any accepted entry had InOverflow=1
- OvfCount  out  8  saturating count of accepted overflow entries

## Operation
- Push when InValid && InReady. Pop when OutValid && OutReady.
- InReady depends only on Count. A full buffer refuses a push even if a pop happens in the same cycle.
- Push and pop in the same cycle (not full, not empty): Count is unchanged, the head advances, and the new entry goes to the tail.
- Pop with OutValid=0 is ignored. Push with InReady=0 is ignored and the producer holds its data.
- FWFT: OutOp, OutResult and OutFlags always show the head entry. When empty they show the last popped entry, or 0 after reset; consumers must qualify with OutValid.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is maintained separately.
- Data is stored unchanged, with no recomputation of flags.
- StickyOverflow is set on any accepted push with InOverflow=1 and cleared by ClearSticky. If a set and a clear occur in the same cycle, the set wins.
- OvfCount increments on each accepted overflow push and saturates at 255. ClearSticky resets it to 0. Clear plus an overflow push in the same cycle gives OvfCount=1.

## Timing
- Reset values: Count=0, OutValid=0, InReady=1, OutOp=0, OutResult=0, OutFlags=0, StickyOverflow=0, OvfCount=0. Both pointers are 0.
- Reset is asynchronous assert and synchronous deassert at the system level. Reset mid-operation discards all entries and status immediately.
- Latency: a push into an empty buffer at edge N gives OutValid=1 with that entry after edge N.
- Full throughput is one push and one pop per cycle in steady state.
- All outputs are registered or decoded from registered state only. There is no combinational path from In* to Out* or from OutReady to InReady.

## Configuration
- ALU_RB_STICKY_EN defined: StickyOverflow, OvfCount and the ClearSticky logic are built as described.
- Not defined: StickyOverflow=0 and OvfCount=0 constantly, ClearSticky is ignored, and no status registers are synthesised. The ports remain in both builds.

## Structure
- Package alu_pkg contains:
  - Op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_ABS=2'b11
  - Flag index constants FLG_OVF=2, FLG_ZERO=1, FLG_NEG=0
  - Default WIDTH=8
- Sub-module alu_rb_fifo holds the storage array, pointers and Count. The top level adds the handshake decode and the sticky status.

## Test plan
- Reset, then push A=100+B=50 (Result=-106, flags 3'b101, Op=00): OutValid=1 next cycle, OutResult=-106, OutFlags=3'b101, StickyOverflow=1, OvfCount=1.
- With OutReady=0, push 4 entries (Result 1,2,3,4): Count=4, InReady=0. A 5th push is not accepted. Pops then return 1,2,3,4 in order, and Count returns to 0.
- With one entry held, assert push and pop every cycle for 10 cycles: Count stays 1, no data is lost or reordered, and the pointers wrap twice.
- When full, assert InValid and OutReady together: the pop happens, the push is refused, and the next cycle has Count=3 and InReady=1.
- Make 300 accepted overflow pushes: OvfCount=255. Then ClearSticky together with an overflow push gives OvfCount=1 and StickyOverflow=1.
- Assert Rst_n low mid-stream with Count=3: all outputs return to their reset values asynchronously. Build without ALU_RB_STICKY_EN and repeat the first scenario: StickyOverflow=0 and OvfCount=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the ALU result path.
//   OP_*     : Op codes produced by the arithmetic unit
//   FLG_*    : bit positions of the flags inside the 3-bit flag vector
//   DEF_WIDTH: default result width of the arithmetic unit
//   pack_flags(): builds the {Overflow, Zero, Negative} flag vector
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  localparam int FLG_OVF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_NEG  = 0;
  localparam int FLAG_W   = 3;

  localparam int DEF_WIDTH = 8;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic ovf,
                                                   input logic zero,
                                                   input logic neg);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLG_OVF]  = ovf;
    f[FLG_ZERO] = zero;
    f[FLG_NEG]  = neg;
    return f;
  endfunction

endpackage

// File: rtl/alu_rb_fifo.sv
// alu_rb_fifo
// First-word-fall-through FIFO storage for alu_result_buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : already-qualified write / read strobes (never push when
//                full, never pop when empty)
//   wr_data    : entry written at the tail on push
//   rd_data    : registered head entry; after the last entry is popped it
//                keeps showing that entry (0 after reset)
//   count      : occupancy, 0..DEPTH
module alu_rb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count_reg, count_next;
  logic [DW-1:0] head_reg, head_next;

  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;

    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_inc;

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase

    // The head register is the registered read port. It loads the incoming
    // entry when that entry becomes the head (empty, or the only entry is
    // leaving this cycle); otherwise a pop advances it to the next stored
    // entry. A pop of the last entry without a push leaves it untouched, so
    // the last popped entry stays visible.
    if (push && ((count_reg == '0) || (pop && (count_reg == CNT_ONE)))) begin
      head_next = wr_data;
    end else if (pop && (count_reg > CNT_ONE)) begin
      head_next = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  // Storage is not reset: clearing count makes every entry invalid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = head_reg;
  assign count   = count_reg;

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Registered output stage behind the 8-bit signed arithmetic unit. Results,
// Op codes and flags are captured via valid/ready into a FWFT FIFO so the
// consumer can stall without stalling the ALU.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   in_valid / in_ready                : producer handshake (in_ready = count < DEPTH)
//   in_op, in_result                   : Op code and signed result
//   in_overflow, in_zero, in_negative  : ALU flags, stored unchanged
//   out_valid / out_ready              : consumer handshake (out_valid = count != 0)
//   out_op, out_result, out_flags      : head entry, flags as {ovf, zero, neg}
//   count                              : occupancy
//   clear_sticky                       : clears sticky_overflow and ovf_count
//   sticky_overflow, ovf_count         : overflow status for software
// Build option: define ALU_RB_STICKY_EN to build the sticky status logic;
// otherwise sticky_overflow and ovf_count are tied to 0.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [WIDTH-1:0]        in_result,
  input  logic                    in_overflow,
  input  logic                    in_zero,
  input  logic                    in_negative,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_op,
  output logic [WIDTH-1:0]        out_result,
  output logic [FLAG_W-1:0]       out_flags,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    clear_sticky,
  output logic                    sticky_overflow,
  output logic [7:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 + WIDTH + FLAG_W;

  logic          push;
  logic          pop;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  // Both handshake outputs decode only the registered count, so there is
  // no path from out_ready to in_ready: a full buffer refuses a push even
  // while it is being popped.
  assign in_ready  = (count < (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;

  assign wr_data = {in_op, in_result, pack_flags(in_overflow, in_zero, in_negative)};

  alu_rb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .count   (count)
  );

  assign {out_op, out_result, out_flags} = rd_data;

`ifdef ALU_RB_STICKY_EN
  logic       sticky_reg, sticky_next;
  logic [7:0] ovf_cnt_reg, ovf_cnt_next;
  logic       ovf_push;

  assign ovf_push = push && in_overflow;

  // A set in the same cycle as a clear wins; a clear with an overflow push
  // restarts the count at 1.
  always_comb begin
    sticky_next  = sticky_reg;
    ovf_cnt_next = ovf_cnt_reg;
    if (ovf_push) begin
      sticky_next = 1'b1;
    end else if (clear_sticky) begin
      sticky_next = 1'b0;
    end
    if (clear_sticky) begin
      ovf_cnt_next = ovf_push ? 8'd1 : 8'd0;
    end else if (ovf_push && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_next = ovf_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg  <= 1'b0;
      ovf_cnt_reg <= '0;
    end else begin
      sticky_reg  <= sticky_next;
      ovf_cnt_reg <= ovf_cnt_next;
    end
  end

  assign sticky_overflow = sticky_reg;
  assign ovf_count       = ovf_cnt_reg;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_overflow     = 1'b0;
  assign ovf_count           = '0;
`endif

endmodule
